// File: rtl/led_code_scheduler.sv
// led_code_scheduler: round-robin arbiter sharing one blink-code LED serialiser among several error sources
module led_code_scheduler #(
  parameter int clock_freq = 50_000_000,
  parameter int frame_ms = 8_400,
  parameter int sources = 4,
  parameter int bits_count = 8,
  parameter int repeat_count = 2,
  parameter logic [bits_count-1:0] idle_code = '0
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [sources*bits_count-1:0]      src_code,
  input  logic [sources-1:0]                 src_valid,
  output logic [sources-1:0]                 src_ack,
  output logic [bits_count-1:0]              parallel_code,
  output logic [(sources > 1 ? $clog2(sources) : 1)-1:0] active_src,
  output logic                               busy
);
  localparam int aw = sources > 1 ? $clog2(sources) : 1;
  localparam int fw = $clog2(repeat_count + 1);
  localparam longint frame_cycles = longint'(frame_ms) * longint'(clock_freq / 1000);
  localparam logic [31:0] frame_last = 32'(frame_cycles - 1);
  localparam logic [fw-1:0] frame_last_n = fw'(repeat_count - 1);
  typedef enum logic {IDLE, SHOW} state_t;
  state_t                r_state;
  logic [31:0]           r_timer;
  logic [fw-1:0]         r_frame;
  logic [aw-1:0]         r_rr_ptr;
  logic [aw-1:0]         r_active_src;
  logic [bits_count-1:0] r_parallel_code;
  logic [sources-1:0]    r_src_ack;
  logic                  r_busy;
  logic [bits_count-1:0] w_codes [sources];
  logic [bits_count-1:0] w_code;
  logic [aw-1:0]         w_grant;
  logic [aw-1:0]         w_idx;
  logic [aw-1:0]         w_next;
  logic                  w_any;
  for (genvar g = 0; g < sources; g++) begin : g_unpack
    assign w_codes[g] = src_code[g*bits_count +: bits_count];
  end
  assign w_next        = aw'((int'(r_active_src) + 1) % sources);
  assign src_ack       = r_src_ack;
  assign parallel_code = r_parallel_code;
  assign active_src    = r_active_src;
  assign busy          = r_busy;
  // first valid source scanning rr_ptr, rr_ptr+1, ... (descending loop so the nearest one wins)
  always_comb begin
    w_any = 1'b0;
    w_grant = '0;
    w_idx = '0;
    w_code = idle_code;
    for (int k = sources - 1; k >= 0; k--) begin
      w_idx = aw'((int'(r_rr_ptr) + k) % sources);
      if (src_valid[w_idx]) begin
        w_any = 1'b1;
        w_grant = w_idx;
        w_code = w_codes[w_idx];
      end
    end
  end
  // IDLE/SHOW sequencer: grant and latch a code, count frames, ack on completion, abort on dropped request
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_frame <= '0;
      r_rr_ptr <= '0;
      r_active_src <= '0;
      r_parallel_code <= idle_code;
      r_src_ack <= '0;
      r_busy <= 1'b0;
    end else begin
      r_src_ack <= '0;
      if (r_state == IDLE) begin
        r_parallel_code <= idle_code;
        r_busy <= 1'b0;
        if (w_any) begin
          r_state <= SHOW;
          r_parallel_code <= w_code;
          r_active_src <= w_grant;
          r_busy <= 1'b1;
          r_timer <= '0;
          r_frame <= '0;
        end
      end else if (!src_valid[r_active_src]) begin
        r_state <= IDLE;
        r_parallel_code <= idle_code;
        r_busy <= 1'b0;
        r_rr_ptr <= w_next;
      end else if (r_timer == frame_last) begin
        r_timer <= '0;
        if (r_frame == frame_last_n) begin
          r_state <= IDLE;
          r_parallel_code <= idle_code;
          r_busy <= 1'b0;
          r_rr_ptr <= w_next;
          r_src_ack[r_active_src] <= 1'b1;
        end else begin
          r_frame <= r_frame + 1'b1;
        end
      end else begin
        r_timer <= r_timer + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_led_code_scheduler.sv
// tb_led_code_scheduler: directed checks of arbitration, frame timing, ack, abort and reset
module tb_led_code_scheduler;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] src_code;
  logic [3:0]  src_valid;
  logic [3:0]  src_ack;
  logic [7:0]  parallel_code;
  logic [1:0]  active_src;
  logic        busy;
  int total = 0;
  int bad = 0;
  led_code_scheduler #(
    .clock_freq(1000), .frame_ms(4), .sources(4), .bits_count(8),
    .repeat_count(2), .idle_code(8'h00)
  ) dut (
    .clk(clk), .reset_n(reset_n), .src_code(src_code), .src_valid(src_valid),
    .src_ack(src_ack), .parallel_code(parallel_code), .active_src(active_src), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_show(input string tag, input logic [7:0] code, input logic [1:0] src);
    chk(tag, 32'({parallel_code, active_src, busy, src_ack}), 32'({code, src, 1'b1, 4'b0000}));
  endtask
  task automatic chk_idle(input string tag, input logic [3:0] ack);
    chk(tag, 32'({parallel_code, busy, src_ack}), 32'({8'h00, 1'b0, ack}));
  endtask
  task automatic chk_rst(input string tag);
    chk(tag, 32'({parallel_code, active_src, busy, src_ack}), 32'd0);
  endtask
  task automatic set_code(input int i, input logic [7:0] c);
    src_code[i*8 +: 8] = c;
  endtask
  task automatic do_reset();
    src_valid = 4'b0000;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask
  initial begin
    reset_n = 1'b0;
    src_valid = 4'b1111;
    src_code = {8'h33, 8'h00, 8'h22, 8'h11};
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_rst("t1_reset");
    end
    reset_n = 1'b1;
    tick();
    chk_show("t1_first_grant", 8'h11, 2'd0);
    do_reset();
    chk_rst("t2_after_reset");
    set_code(2, 8'hA5);
    src_valid = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_show("t2_show", 8'hA5, 2'd2);
    end
    tick();
    chk_idle("t2_ack", 4'b0100);
    tick();
    chk_show("t2_regrant", 8'hA5, 2'd2);
    do_reset();
    set_code(0, 8'h11);
    set_code(1, 8'h22);
    set_code(3, 8'h33);
    src_valid = 4'b1011;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_show("t3_src0", 8'h11, 2'd0);
    end
    tick();
    chk_idle("t3_ack0", 4'b0001);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_show("t3_src1", 8'h22, 2'd1);
    end
    tick();
    chk_idle("t3_ack1", 4'b0010);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_show("t3_src3", 8'h33, 2'd3);
    end
    tick();
    chk_idle("t3_ack3", 4'b1000);
    tick();
    chk_show("t3_wrap_src0", 8'h11, 2'd0);
    do_reset();
    set_code(2, 8'h77);
    src_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_show("t4_src1", 8'h22, 2'd1);
    end
    src_valid = 4'b0000;
    tick();
    chk_idle("t4_abort_no_ack", 4'b0000);
    src_valid = 4'b0110;
    tick();
    chk_show("t4_next_src2", 8'h77, 2'd2);
    tick();
    chk_show("t4_src2_hold", 8'h77, 2'd2);
    do_reset();
    set_code(0, 8'h5A);
    src_valid = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_show("t5_latched", 8'h5A, 2'd0);
      if (i == 2) set_code(0, 8'hC3);
    end
    tick();
    chk_idle("t5_ack0", 4'b0001);
    tick();
    chk_show("t5_new_code", 8'hC3, 2'd0);
    do_reset();
    set_code(0, 8'h11);
    set_code(3, 8'h33);
    src_valid = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_show("t6_src3", 8'h33, 2'd3);
    end
    reset_n = 1'b0;
    src_valid = 4'b1001;
    tick();
    chk_rst("t6_mid_reset");
    reset_n = 1'b1;
    tick();
    chk_show("t6_src0_first", 8'h11, 2'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
